// File: rtl/stepdown_pkg.sv
// -----------------------------------------------------------------------------
// stepdown_pkg
// Shared definitions for the stepdown phase controller: the 3-bit phase state
// encoding, default timing constants and the dead-time clamp helper.
// -----------------------------------------------------------------------------
package stepdown_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_TRI   = 3'd1,
    ST_DTH   = 3'd2,
    ST_HS    = 3'd3,
    ST_DTL   = 3'd4,
    ST_LS    = 3'd5,
    ST_FAULT = 3'd6
  } phase_state_e;

  localparam int TMR_W_DEF    = 8;
  localparam int TON_MIN_DEF  = 8;
  localparam int TOFF_MIN_DEF = 4;
  localparam int BLANK_DEF    = 6;
  localparam int OCP_MAX_DEF  = 4;
  localparam int SS_W_DEF     = 8;
  localparam int SS_DIV_DEF   = 4;

  // A dead-time setting of zero still has to give one both-off cycle.
  function automatic int unsigned dt_cycles(input int unsigned cfg);
    return (cfg == 32'd0) ? 32'd1 : cfg;
  endfunction

endpackage

// File: rtl/stepdown_phase_ctrl_if.sv
// -----------------------------------------------------------------------------
// stepdown_phase_ctrl_if
// Bundles the modulator/comparator inputs and the gate-drive/status outputs of
// the stepdown phase controller.
//   master : drives en, pwm_req, ocp, zcd, dt_cfg; observes the outputs
//   slave  : the controller itself
// -----------------------------------------------------------------------------
interface stepdown_phase_ctrl_if #(
  parameter int TMR_W = 8,
  parameter int SS_W  = 8
);
  logic             en;
  logic             pwm_req;
  logic             ocp;
  logic             zcd;
  logic [TMR_W-1:0] dt_cfg;
  logic             hs_on;
  logic             ls_on;
  logic [SS_W-1:0]  ss_level;
  logic             ss_done;
  logic             fault;
  logic [2:0]       state;

  modport master (
    output en, pwm_req, ocp, zcd, dt_cfg,
    input  hs_on, ls_on, ss_level, ss_done, fault, state
  );

  modport slave (
    input  en, pwm_req, ocp, zcd, dt_cfg,
    output hs_on, ls_on, ss_level, ss_done, fault, state
  );
endinterface

// File: rtl/stepdown_phase_tmr.sv
// -----------------------------------------------------------------------------
// stepdown_phase_tmr
// Loadable down-counter shared by dead-time, minimum-on and minimum-off timing.
// A load of N makes o_expire true in the N-th cycle after the load edge, so the
// owning state lasts exactly N cycles. The counter parks at zero.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load i_load_val at the next edge
//   o_value        : current count
//   o_expire       : count == 1
// -----------------------------------------------------------------------------
module stepdown_phase_tmr #(
  parameter int TMR_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  output logic [TMR_W-1:0] o_value,
  output logic             o_expire
);

  logic [TMR_W-1:0] r_count;

  // Count register: load wins, otherwise decrement until zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= {TMR_W{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != {TMR_W{1'b0}}) begin
      r_count <= r_count - TMR_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_value  = r_count;
  assign o_expire = (r_count == TMR_W'(1));

endmodule

// File: rtl/stepdown_phase_ctrl.sv
// -----------------------------------------------------------------------------
// stepdown_phase_ctrl
// Sequences the stepdown high-side / low-side gate drive with break-before-make
// dead time, minimum on/off times, ocp blanking, DCM tristate on zero-cross, an
// ocp fault latch and a soft-start ramp.
//   CELCLK, CELRSTN  : clock, asynchronous active-low reset
//   CELV, CELG, SUB  : supply/ground/substrate ties, no logical function
//   bus (slave)      : en, pwm_req, ocp, zcd, dt_cfg in;
//                      hs_on, ls_on, ss_level, ss_done, fault, state out
// All outputs are registered and change one cycle after their cause.
// -----------------------------------------------------------------------------
module stepdown_phase_ctrl
  import stepdown_pkg::*;
#(
  parameter int TMR_W    = TMR_W_DEF,
  parameter int TON_MIN  = TON_MIN_DEF,
  parameter int TOFF_MIN = TOFF_MIN_DEF,
  parameter int BLANK    = BLANK_DEF,
  parameter int OCP_MAX  = OCP_MAX_DEF,
  parameter int SS_W     = SS_W_DEF,
  parameter int SS_DIV   = SS_DIV_DEF
) (
  input  logic                 CELCLK,
  input  logic                 CELRSTN,
  input  logic                 CELV,
  input  logic                 CELG,
  input  logic                 SUB,
  stepdown_phase_ctrl_if.slave bus
);

  localparam int OCP_W = $clog2(OCP_MAX + 1);
  // HS cycle k holds timer value TON_MIN-k+1, so ocp counts once value <= this.
  // Requires BLANK < TON_MIN.
  localparam logic [TMR_W-1:0]  BLANK_THR  = TMR_W'(TON_MIN - BLANK);
  localparam logic [SS_W-1:0]   SS_MAX     = {SS_W{1'b1}};
  localparam logic [SS_DIV-1:0] SS_PRE_MAX = {SS_DIV{1'b1}};

  phase_state_e      r_state, w_state_nxt;
  logic              r_hs_on, r_ls_on, r_fault;
  logic              w_hs_nxt, w_ls_nxt, w_fault_nxt;
  logic [OCP_W-1:0]  r_ocp_cnt, w_ocp_cnt_nxt, w_ocp_inc;
  logic              r_ocp_hold, w_ocp_hold_nxt;
  logic [SS_DIV-1:0] r_ss_pre, w_ss_pre_nxt;
  logic [SS_W-1:0]   r_ss_level, w_ss_level_nxt;
  logic              r_ss_done;
  logic              w_tmr_load, w_tmr_exp, w_min_done, w_ocp_trip;
  logic [TMR_W-1:0]  w_tmr_load_val, w_tmr_val;
  logic              w_unused_supply;

  assign w_unused_supply = CELV ^ CELG ^ SUB;

  stepdown_phase_tmr #(.TMR_W(TMR_W)) u_tmr (
    .i_clk      (CELCLK),
    .i_rst_n    (CELRSTN),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_load_val),
    .o_value    (w_tmr_val),
    .o_expire   (w_tmr_exp)
  );

  // The timer parks at 0 after expiry, so <=1 means the minimum time is met.
  assign w_min_done = (w_tmr_val <= TMR_W'(1));
  assign w_ocp_trip = bus.ocp && (w_tmr_val <= BLANK_THR);
  assign w_ocp_inc  = r_ocp_cnt + OCP_W'(1);

  // State, gate outputs, ocp bookkeeping and soft-start registers.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      r_state    <= ST_OFF;
      r_hs_on    <= 1'b0;
      r_ls_on    <= 1'b0;
      r_fault    <= 1'b0;
      r_ocp_cnt  <= {OCP_W{1'b0}};
      r_ocp_hold <= 1'b0;
      r_ss_pre   <= {SS_DIV{1'b0}};
      r_ss_level <= {SS_W{1'b0}};
      r_ss_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hs_on    <= w_hs_nxt;
      r_ls_on    <= w_ls_nxt;
      r_fault    <= w_fault_nxt;
      r_ocp_cnt  <= w_ocp_cnt_nxt;
      r_ocp_hold <= w_ocp_hold_nxt;
      r_ss_pre   <= w_ss_pre_nxt;
      r_ss_level <= w_ss_level_nxt;
      r_ss_done  <= (w_ss_level_nxt == SS_MAX);
    end
  end

  // Next-state logic with ocp counting and the pwm re-arm hold.
  always_comb begin
    w_state_nxt    = r_state;
    w_ocp_cnt_nxt  = r_ocp_cnt;
    // Hold is released by any cycle with pwm_req low; a trip below re-sets it.
    w_ocp_hold_nxt = r_ocp_hold && bus.pwm_req;
    if (!bus.en) begin
      w_state_nxt    = ST_OFF;
      w_ocp_cnt_nxt  = {OCP_W{1'b0}};
      w_ocp_hold_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_OFF: w_state_nxt = ST_TRI;
        ST_TRI: begin
          if (bus.pwm_req && !r_ocp_hold) w_state_nxt = ST_DTH;
          else                            w_state_nxt = ST_TRI;
        end
        ST_DTH: begin
          if (w_tmr_exp) w_state_nxt = ST_HS;
          else           w_state_nxt = ST_DTH;
        end
        ST_HS: begin
          // A current-limit trip overrides the minimum on-time.
          if (w_ocp_trip) begin
            w_ocp_hold_nxt = 1'b1;
            w_ocp_cnt_nxt  = w_ocp_inc;
            if (w_ocp_inc == OCP_W'(OCP_MAX)) w_state_nxt = ST_FAULT;
            else                              w_state_nxt = ST_DTL;
          end else if (w_min_done && !bus.pwm_req) begin
            w_state_nxt   = ST_DTL;
            w_ocp_cnt_nxt = {OCP_W{1'b0}};
          end else begin
            w_state_nxt = ST_HS;
          end
        end
        ST_DTL: begin
          if (w_tmr_exp) w_state_nxt = ST_LS;
          else           w_state_nxt = ST_DTL;
        end
        ST_LS: begin
          if (w_min_done && bus.pwm_req && !r_ocp_hold) w_state_nxt = ST_DTH;
          else if (w_min_done && bus.zcd)               w_state_nxt = ST_TRI;
          else                                          w_state_nxt = ST_LS;
        end
        ST_FAULT: w_state_nxt = ST_FAULT;
        default:  w_state_nxt = ST_OFF;
      endcase
    end
  end

  // Output decode from the next state, plus the timer load on state entry.
  always_comb begin
    w_hs_nxt    = (w_state_nxt == ST_HS);
    w_ls_nxt    = (w_state_nxt == ST_LS);
    w_fault_nxt = (w_state_nxt == ST_FAULT);
    w_tmr_load  = (w_state_nxt != r_state);
    case (w_state_nxt)
      ST_DTH, ST_DTL: w_tmr_load_val = TMR_W'(dt_cycles(32'(bus.dt_cfg)));
      ST_HS:          w_tmr_load_val = TMR_W'(TON_MIN);
      ST_LS:          w_tmr_load_val = TMR_W'(TOFF_MIN);
      default:        w_tmr_load_val = {TMR_W{1'b0}};
    endcase
  end

  // Soft-start ramp: one step per 2^SS_DIV active cycles, frozen in FAULT.
  always_comb begin
    w_ss_pre_nxt   = r_ss_pre;
    w_ss_level_nxt = r_ss_level;
    if (!bus.en || (r_state == ST_OFF)) begin
      w_ss_pre_nxt   = {SS_DIV{1'b0}};
      w_ss_level_nxt = {SS_W{1'b0}};
    end else if (r_state == ST_FAULT) begin
      w_ss_pre_nxt   = r_ss_pre;
      w_ss_level_nxt = r_ss_level;
    end else begin
      w_ss_pre_nxt = r_ss_pre + SS_DIV'(1);
      if ((r_ss_pre == SS_PRE_MAX) && (r_ss_level != SS_MAX)) w_ss_level_nxt = r_ss_level + SS_W'(1);
      else                                                    w_ss_level_nxt = r_ss_level;
    end
  end

  assign bus.hs_on    = r_hs_on;
  assign bus.ls_on    = r_ls_on;
  assign bus.fault    = r_fault;
  assign bus.ss_level = r_ss_level;
  assign bus.ss_done  = r_ss_done;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_stepdown_phase_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stepdown_phase_ctrl
// Scoreboard bench: each stimulus cycle a phase-level reference model predicts
// the outputs after the next edge and queues them; a negedge monitor pops and
// compares, and also watches the gate overlap / direct-toggle invariant.
// -----------------------------------------------------------------------------
module tb_stepdown_phase_ctrl;

  localparam int TON_MIN  = 8;
  localparam int TOFF_MIN = 4;
  localparam int BLANK    = 6;
  localparam int OCP_MAX  = 4;

  localparam int P_OFF = 0, P_TRI = 1, P_DTH = 2, P_HS = 3, P_DTL = 4, P_LS = 5, P_FAULT = 6;

  logic clk = 1'b0;
  logic rst_n;

  stepdown_phase_ctrl_if #(.TMR_W(8), .SS_W(8)) bus ();

  stepdown_phase_ctrl dut (
    .CELCLK  (clk),
    .CELRSTN (rst_n),
    .CELV    (1'b1),
    .CELG    (1'b0),
    .SUB     (1'b0),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Scoreboard and counters (counters written only by the monitor)
  logic [14:0] sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int tmo_events = 0;
  int tmo_seen   = 0;
  int cyc        = 0;

  // Reference model: phase, cycles completed in it, dead time latched on entry,
  // consecutive ocp trips, re-arm hold, and total active (ramping) cycles.
  int m_phase, m_age, m_dur, m_trips, m_active;
  bit m_hold;

  function automatic logic [14:0] pack_exp(input int ph, input int act);
    int lvl;
    lvl = act / 16;
    if (lvl > 255) lvl = 255;
    return {3'(ph), (ph == P_HS), (ph == P_LS), 8'(lvl), (lvl == 255), (ph == P_FAULT)};
  endfunction

  task automatic model_step(input bit e, input bit p, input bit o, input bit z, input int d);
    int cur, age, nxt;
    bit hold_n;
    cur    = m_phase;
    age    = m_age + 1;
    nxt    = cur;
    hold_n = m_hold && p;
    if (!e) begin
      nxt = P_OFF; hold_n = 1'b0; m_trips = 0; m_active = 0;
    end else begin
      if (cur != P_OFF && cur != P_FAULT) m_active++;
      case (cur)
        P_OFF: nxt = P_TRI;
        P_TRI: if (p && !m_hold) nxt = P_DTH;
        P_DTH: if (age >= m_dur) nxt = P_HS;
        P_HS: begin
          if (o && age > BLANK) begin
            m_trips++;
            hold_n = 1'b1;
            nxt = (m_trips == OCP_MAX) ? P_FAULT : P_DTL;
          end else if (age >= TON_MIN && !p) begin
            nxt = P_DTL;
            m_trips = 0;
          end
        end
        P_DTL: if (age >= m_dur) nxt = P_LS;
        P_LS: begin
          if (age >= TOFF_MIN) begin
            if (p && !m_hold) nxt = P_DTH;
            else if (z)       nxt = P_TRI;
          end
        end
        default: nxt = cur;
      endcase
    end
    if (nxt != cur) begin
      m_age = 0;
      m_dur = (d == 0) ? 1 : d;
    end else begin
      m_age = age;
    end
    m_phase = nxt;
    m_hold  = hold_n;
    sb_q.push_back(pack_exp(m_phase, m_active));
  endtask

  task automatic step(input bit e, input bit p, input bit o, input bit z, input int d);
    bus.en = e; bus.pwm_req = p; bus.ocp = o; bus.zcd = z; bus.dt_cfg = 8'(d);
    model_step(e, p, o, z, d);
    @(posedge clk);
    #1;
  endtask

  // Drive constant inputs until the DUT reaches (neg=0) or leaves (neg=1) a state.
  task automatic run_until(input int ph, input bit neg, input bit e, input bit p,
                           input bit o, input bit z, input int d, input int maxc);
    int n;
    n = 0;
    while (((int'(bus.state) == ph) == neg) && (n < maxc)) begin
      step(e, p, o, z, d);
      n++;
    end
    if ((int'(bus.state) == ph) == neg) begin
      tmo_events++;
      $display("FAIL wait_state: actual state %0d, required %s state %0d within %0d cycles",
               bus.state, neg ? "leaving" : "reaching", ph, maxc);
    end
  endtask

  logic [14:0] exp_v, act_v;
  logic        prev_hs = 1'b0, prev_ls = 1'b0;

  // Monitor: compare queued predictions, gate invariant and wait timeouts.
  always @(negedge clk) begin
    cyc++;
    act_v = {bus.state, bus.hs_on, bus.ls_on, bus.ss_level, bus.ss_done, bus.fault};
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs @%0d: actual st=%0d hs=%0b ls=%0b ss=%0d done=%0b flt=%0b, required st=%0d hs=%0b ls=%0b ss=%0d done=%0b flt=%0b",
                 cyc, act_v[14:12], act_v[11], act_v[10], act_v[9:2], act_v[1], act_v[0],
                 exp_v[14:12], exp_v[11], exp_v[10], exp_v[9:2], exp_v[1], exp_v[0]);
      end
    end
    if (rst_n) begin
      n_checks++;
      if ((bus.hs_on && bus.ls_on) || (prev_hs && bus.ls_on) || (prev_ls && bus.hs_on)) begin
        n_fail++;
        $display("FAIL gate_overlap @%0d: actual hs=%0b ls=%0b (prev hs=%0b ls=%0b), required no overlap or direct toggle",
                 cyc, bus.hs_on, bus.ls_on, prev_hs, prev_ls);
      end
    end
    prev_hs = bus.hs_on;
    prev_ls = bus.ls_on;
    while (tmo_seen != tmo_events) begin
      tmo_seen++;
      n_checks++;
      n_fail++;
    end
  end

  initial begin
    bit p;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.pwm_req = 1'b0; bus.ocp = 1'b0; bus.zcd = 1'b0; bus.dt_cfg = 8'd0;
    m_phase = P_OFF; m_age = 0; m_dur = 1; m_trips = 0; m_active = 0; m_hold = 1'b0;

    // Reset values
    repeat (3) begin
      sb_q.push_back(15'd0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;

    // Start-up: OFF -> TRI, first ramp step after 16 active cycles
    repeat (20) step(1, 0, 0, 0, 0);

    // Dead time 3, then 0
    run_until(P_HS, 0, 1, 1, 0, 0, 3, 20);
    repeat (10) step(1, 1, 0, 0, 3);
    run_until(P_LS, 0, 1, 0, 0, 0, 3, 20);
    repeat (6) step(1, 0, 0, 0, 3);
    run_until(P_HS, 0, 1, 1, 0, 0, 0, 20);
    repeat (9) step(1, 1, 0, 0, 0);
    run_until(P_LS, 0, 1, 0, 0, 0, 0, 20);
    repeat (5) step(1, 0, 0, 0, 0);

    // Minimum on-time with a 2-cycle request, minimum off-time with early request
    repeat (2) step(1, 1, 0, 0, 0);
    repeat (12) step(1, 0, 0, 0, 0);
    run_until(P_LS, 0, 1, 0, 0, 0, 0, 20);
    repeat (8) step(1, 1, 0, 0, 0);
    run_until(P_LS, 0, 1, 0, 0, 0, 2, 30);

    // Blanking and current limit, then re-arm only after pwm_req drops
    run_until(P_HS, 0, 1, 1, 0, 0, 2, 20);
    run_until(P_HS, 1, 1, 1, 1, 0, 2, 20);
    repeat (15) step(1, 1, 0, 0, 2);
    step(1, 0, 0, 0, 2);
    run_until(P_HS, 0, 1, 1, 0, 0, 2, 30);
    repeat (9) step(1, 1, 0, 0, 2);
    run_until(P_LS, 0, 1, 0, 0, 0, 2, 20);

    // Consecutive ocp-terminated pulses into FAULT
    for (int k = 0; k < 6 && int'(bus.state) != P_FAULT; k++) begin
      run_until(P_HS, 0, 1, 1, 0, 0, 1, 30);
      run_until(P_HS, 1, 1, 1, 1, 0, 1, 20);
      if (int'(bus.state) != P_FAULT) step(1, 0, 0, 0, 1);
    end
    run_until(P_FAULT, 0, 1, 1, 0, 0, 1, 1);
    for (int k = 0; k < 40; k++) step(1, k[2], k[0], k[1], 1);
    repeat (2) step(0, 0, 0, 0, 1);
    repeat (20) step(1, 0, 0, 0, 1);

    // DCM tristate on zero-cross, then en abort mid-HS
    run_until(P_HS, 0, 1, 1, 0, 0, 2, 20);
    repeat (9) step(1, 1, 0, 0, 2);
    run_until(P_LS, 0, 1, 0, 0, 0, 2, 20);
    run_until(P_TRI, 0, 1, 0, 0, 1, 2, 10);
    run_until(P_HS, 0, 1, 1, 0, 0, 2, 20);
    repeat (3) step(1, 1, 0, 0, 2);
    repeat (3) step(0, 1, 0, 0, 2);

    // Soft-start saturation
    repeat (4100) step(1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);

    // Randomized operation
    p = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) p = !p;
      step($urandom_range(0, 299) != 0, p, $urandom_range(0, 11) == 0,
           $urandom_range(0, 2) == 0, int'($urandom_range(0, 4)));
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stepdown_phase_ctrl.md
Name: stepdown_phase_ctrl

Overview:
- Synchronous controller that sequences the stepdown power stage gate-drive inverters (high-side and low-side).
- Sits between the PWM modulator/comparators and the driver inverter chain in the stepdown core state logic.
- Enforces break-before-make dead time, minimum on/off times, current-limit blanking, DCM tristate on zero-cross, ocp fault latch and a soft-start ramp count.

Parameters:
- TMR_W, 8, width of the phase timer and of dt_cfg.
- TON_MIN, 8, minimum HS on-time in cycles (>=1).
- TOFF_MIN, 4, minimum LS on-time in cycles (>=1).
- BLANK, 6, cycles at HS start during which ocp is ignored (< TON_MIN allowed).
- OCP_MAX, 4, consecutive ocp-terminated HS pulses that trigger FAULT.
- SS_W, 8, soft-start level width.
- SS_DIV, 4, log2 cycles per soft-start increment.

Ports:
- CELCLK, input, 1, controller clock.
- CELRSTN, input, 1, asynchronous active-low reset.
- CELV, input, 1, brick supply; no logical function.
- CELG, input, 1, brick ground; no logical function.
- SUB, input, 1, substrate tie; no logical function.
- en, input, 1, converter enable.
- pwm_req, input, 1, modulator request for HS on.
- ocp, input, 1, HS overcurrent comparator.
- zcd, input, 1, LS zero-cross comparator.
- dt_cfg, input, TMR_W, dead-time cycles.
- hs_on, output, 1, HS gate enable (registered).
- ls_on, output, 1, LS gate enable (registered).
- ss_level, output, SS_W, soft-start reference code.
- ss_done, output, 1, ss_level saturated at all-ones.
- fault, output, 1, latched ocp fault.
- state, output, 3, current state code (observability).

Behaviour:
- Clock and reset: one clock CELCLK; CELRSTN is asynchronous, active-low.
- Reset values: state=OFF, hs_on=0, ls_on=0, ss_level=0, ss_done=0, fault=0, timer=0, ocp count=0, ocp_hold=0.
- Inputs are pre-synchronized. Every transition and output change takes effect one cycle after its condition is sampled.
- States and outputs:
  - OFF: both gates off.
  - TRI: both off.
  - DTH: both off.
  - HS: hs_on=1.
  - DTL: both off.
  - LS: ls_on=1.
  - FAULT: both off, fault=1.
- Invariant: hs_on and ls_on are never 1 in the same cycle, and never toggle directly into each other.
- Dead time: DTH and DTL last max(dt_cfg,1) cycles. dt_cfg is sampled on entry, so dt_cfg=0 gives 1 cycle.
- Transitions:
  - OFF: en=1 -> TRI.
  - TRI: pwm_req=1 & !ocp_hold -> DTH.
  - DTH: expiry -> HS; the timer loads TON_MIN.
  - HS: exit to DTL only after TON_MIN cycles, when pwm_req=0. Exception: ocp=1 after the first BLANK HS cycles forces DTL even before TON_MIN, sets ocp_hold, and increments the ocp count.
  - HS termination by pwm_req clears the ocp count.
  - Reaching ocp count = OCP_MAX goes to FAULT instead of DTL, with both gates off next cycle.
  - DTL: expiry -> LS; the timer loads TOFF_MIN.
  - LS: after TOFF_MIN, pwm_req=1 & !ocp_hold -> DTH; otherwise zcd=1 -> TRI. If both are true, pwm_req wins.
  - ocp_hold: clears in any cycle with pwm_req=0.
  - FAULT: stays until en=0.
- en=0 in any state: next state OFF, both gates off next cycle, ss_level and ss_done cleared, ocp count and ocp_hold cleared, fault cleared.
- Soft start:
  - While state != OFF and != FAULT, ss_level increments once every 2^SS_DIV cycles.
  - It saturates at 2^SS_W-1; ss_done=1 from the cycle ss_level reaches all-ones.
  - ss_level is frozen in FAULT.
- Timer: loadable down-counter. "Expiry" means count==1 at the sample edge, so a load of N gives exactly N cycles in the state.

Decomposition:
- Shared package stepdown_pkg:
  - State enum, 3-bit encoding: OFF=0, TRI=1, DTH=2, HS=3, DTL=4, LS=5, FAULT=6.
  - Default TON_MIN, TOFF_MIN, BLANK and OCP_MAX constants.
- One sub-module, stepdown_phase_tmr: TMR_W loadable down-counter with load, value and expire outputs, shared by dead-time, min-on and min-off timing.

Test Plan:
- Reset and start: CELRSTN=0, then en=1 with pwm_req=0 -> hs_on=ls_on=0, state OFF then TRI; ss_level reaches 1 after 16 cycles.
- Dead time: dt_cfg=3, pwm_req=1 held -> exactly 3 both-off cycles, then hs_on=1 for at least 8 cycles. Drop pwm_req -> 3 both-off cycles, then ls_on=1. Repeat with dt_cfg=0 -> 1 both-off cycle.
- Minimum times: pwm_req pulse of 2 cycles -> hs_on still high 8 cycles. pwm_req re-asserted 1 cycle into LS -> ls_on stays 4 cycles before DTH.
- Blanking and limit: ocp=1 on HS cycles 1-6 -> ignored. ocp=1 on HS cycle 7 -> hs_on=0 next cycle, DTL entered; no new HS until pwm_req drops and re-rises.
- Fault: 4 consecutive ocp-terminated pulses -> fault=1, both gates off, ss_level frozen. en=0 -> OFF with fault=0. en=1 -> ss ramp restarts at 0.
- DCM and abort: in LS after 4 cycles, zcd=1 with pwm_req=0 -> TRI, both off. en=0 mid-HS -> hs_on=0 next cycle. Assert hs_on&ls_on never both 1 across all tests.
